// File: rtl/demux1_5.sv
// demux1_5: registered one-hot 1:5 stream demux; ports clk/rst, in_valid/in_ready/in_data/in_sel, out_valid/out_ready/out_data, err pulse, err_cnt
module demux1_5 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [4:0]       in_sel,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic [7:0]       err_cnt
);
  logic             full;
  logic [WIDTH-1:0] data_q;
  logic [4:0]       sel_q;
  logic             legal;
  logic             out_fire;
  logic             in_fire;
  assign legal     = (in_sel != 5'd0) && ((in_sel & (in_sel - 5'd1)) == 5'd0);
  assign out_fire  = full & |(sel_q & out_ready);
  assign in_ready  = ~full | out_fire;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = {5{full}} & sel_q;
  assign out_data  = data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= in_fire & ~legal;
      if (in_fire & legal) begin
        data_q <= in_data;
        sel_q  <= in_sel;
        full   <= 1'b1;
      end else if (out_fire) begin
        full <= 1'b0;
      end
      if (in_fire & ~legal & (err_cnt != 8'hff)) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_demux1_5.sv
// tb_demux1_5: directed and random checks of demux1_5 against a behavioural model
module tb_demux1_5;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_sel = '0;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready = '0;
  logic [31:0] out_data;
  logic        err;
  logic [7:0]  err_cnt;
  int checks = 0;
  int errors = 0;
  bit          m_full;
  logic [31:0] m_data;
  int          m_dest;
  int          m_cnt;
  bit          m_err;
  demux1_5 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask
  task automatic check_outs();
    check("out_valid", {27'd0, out_valid}, m_full ? 32'(1 << m_dest) : 32'd0);
    if (m_full) check("out_data", out_data, m_data);
    check("err", {31'd0, err}, {31'd0, m_err});
    check("err_cnt", {24'd0, err_cnt}, 32'(m_cnt));
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    m_full = 0; m_data = '0; m_dest = 0; m_cnt = 0; m_err = 0;
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_outs();
  endtask
  task automatic step(input bit v, input logic [31:0] d, input logic [4:0] s, input logic [4:0] r);
    bit legal, drain, rdy, fire;
    in_valid = v; in_data = d; in_sel = s; out_ready = r;
    #1;
    legal = $countones(s) == 1;
    drain = m_full && r[m_dest];
    rdy = !m_full || drain;
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    fire = v && rdy;
    @(posedge clk);
    m_err = fire && !legal;
    if (fire && legal) begin
      m_full = 1;
      m_data = d;
      for (int i = 0; i < 5; i++) if (s[i]) m_dest = i;
    end else if (drain) m_full = 0;
    if (fire && !legal && m_cnt < 255) m_cnt++;
    #1;
    check_outs();
  endtask
  initial begin
    logic [4:0] s;
    do_reset(2);
    step(0, 32'h0, 5'b0, 5'b0);
    for (int i = 0; i < 5; i++) step(1, 32'hA5A5_0001 + i, 5'(1 << i), 5'b11111);
    step(0, 32'h0, 5'b0, 5'b11111);
    check("routing_done", {31'd0, m_full}, 32'd0);
    step(1, 32'hDEAD_BEEF, 5'b01000, 5'b11111);
    repeat (4) step(1, 32'h1234_5678, 5'b00001, 5'b10111);
    check("bp_hold_valid", {27'd0, out_valid}, 32'b01000);
    check("bp_hold_data", out_data, 32'hDEAD_BEEF);
    step(1, 32'h1234_5678, 5'b00001, 5'b11111);
    step(0, 32'h0, 5'b0, 5'b11111);
    step(1, 32'h1, 5'b00000, 5'b11111);
    step(1, 32'h2, 5'b00110, 5'b11111);
    check("malformed_cnt", {24'd0, err_cnt}, 32'd2);
    step(0, 32'h0, 5'b0, 5'b0);
    step(1, 32'hCAFE_0000, 5'b00001, 5'b0);
    step(1, 32'h3, 5'b11000, 5'b00001);
    check("drain_malformed_valid", {27'd0, out_valid}, 32'd0);
    for (int i = 0; i < 260; i++) step(1, 32'(i), (i % 2) ? 5'b11111 : 5'b00000, 5'b11111);
    check("sat_cnt", {24'd0, err_cnt}, 32'd255);
    step(1, 32'h0BAD_F00D, 5'b10000, 5'b0);
    do_reset(1);
    check("midrst_cnt", {24'd0, err_cnt}, 32'd0);
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(3) != 0) ? 5'(1 << $urandom_range(4)) : 5'($urandom);
      step(1'($urandom), $urandom, s, 5'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux1_5.md
# demux1_5

Registered one-hot demultiplexer that steers a single valid/ready stream to one of five downstream consumers; it is the send-side counterpart of the team's five-way one-hot select mux. A producer (e.g. the LSU or IFU request path) presents a data word and a 5-bit one-hot destination. The block captures the word into a one-entry buffer and raises `valid` on exactly the addressed output. Malformed selects are consumed, dropped, flagged and counted.

## Interface
- `WIDTH`, 32, data word width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  producer has a word
- `in_ready`  out  1  block accepts the word this cycle
- `in_data`  in  WIDTH  payload
- `in_sel`  in  5  one-hot destination; bit i selects consumer i
- `out_valid`  out  5  per-consumer valid; at most one bit set
- `out_ready`  in  5  per-consumer ready
- `out_data`  out  WIDTH  buffered payload, shared by all five consumers
- `err`  out  1  one-cycle pulse: a malformed select was consumed
- `err_cnt`  out  8  saturating count of malformed selects

## Operation
- State: `full` flag, `data_q[WIDTH-1:0]`, `sel_q[4:0]`, `err`, `err_cnt`.
- Select legality: `in_sel` is legal iff exactly one bit is set. Zero bits or two or more bits are malformed.
- Input fire: `in_valid & in_ready`.
- Output fire: `full & |(sel_q & out_ready)`. Only the ready bit of the selected consumer counts; ready on other consumers is ignored.
- `in_ready = ~full | out_fire`. This is a pass-through on drain, so throughput is 1 word/cycle with no bubble.
- `out_valid = {5{full}} & sel_q`. `out_data = data_q`.
- On input fire with a legal select:
  - `data_q <= in_data`, `sel_q <= in_sel`, `full <= 1`.
  - This holds even if `out_fire` happens in the same cycle (replace).
- On input fire with a malformed select:
  - The buffer is not loaded.
  - `full <= full & ~out_fire`, i.e. a drain in the same cycle still empties the buffer.
  - `err <= 1` next cycle.
  - `err_cnt` increments, saturating at 255.
- On out_fire with no legal input fire: `full <= 0`. `data_q` and `sel_q` hold their stale values; they are not observable because `out_valid` is 0.
- `err` is 0 in every cycle not following a malformed fire.
- With `in_valid` low, no state changes other than the drain.
- Stability: while `full` and not drained, `out_valid` and `out_data` hold constant, regardless of `in_*` activity.

## Timing
- Reset: `full=0`, `data_q=0`, `sel_q=0`, `err=0`, `err_cnt=0`. This gives `out_valid=5'b0`, `out_data=0`, `in_ready=1` in the cycle after `rst` is sampled high.
- `rst` mid-operation: a buffered word is discarded without being delivered. `err_cnt` clears.
- Latency: a word accepted at edge N appears on `out_valid`/`out_data` after edge N. It can be consumed at edge N+1.
- Simultaneous drain and legal accept at edge N: the new word is visible after N; `out_valid` never drops.
- Backpressure: with `full=1` and the selected `out_ready=0`, `in_ready=0`, so the producer must hold.
- `in_ready` depends combinationally on `out_ready`. `out_valid` and `out_data` are purely registered.
- Saturation: when `err_cnt=255`, a further malformed fire still pulses `err`; `err_cnt` stays 255.

## Test plan
- Reset then idle:
  - Stimulus: `rst` high 2 cycles, then low with `in_valid=0`.
  - Required: `out_valid=0`, `out_data=0`, `in_ready=1`, `err=0`, `err_cnt=0`.
- Routing:
  - Stimulus: send `0xA5A5_0001` with sel `5'b00001`, then `0x...0002` with `5'b00010`, up to `5'b10000`, all `out_ready=5'b11111`.
  - Required: each word appears one cycle later on only the matching `out_valid` bit, with the matching data. 5 words complete in 6 cycles.
- Backpressure:
  - Stimulus: send `0xDEAD_BEEF` to consumer 3 with `out_ready=5'b10111` (bit 3 low) for 4 cycles, with a second word pending.
  - Required: `out_valid=5'b01000` and data stable, `in_ready=0`.
  - Stimulus: raise bit 3.
  - Required: the first word drains and the second is accepted at the same edge.
- Malformed select:
  - Stimulus: `in_sel=5'b00000`, then `5'b00110`.
  - Required: both accepted (`in_ready=1`), `out_valid` stays 0, `err` pulses on each following cycle, `err_cnt=2`.
- Malformed during drain:
  - Stimulus: buffer full to consumer 0, `out_ready[0]=1`, and in the same cycle `in_sel=5'b11000`.
  - Required: next cycle `out_valid=0`, `err=1`, `err_cnt` +1.
- Saturation and mid-run reset:
  - Stimulus: 260 malformed fires.
  - Required: `err_cnt=255`.
  - Stimulus: assert `rst` with a word buffered.
  - Required: next cycle `err_cnt=0`, `out_valid=0`.
